uart_loopback_scoreboard: RTL and testbench

- Parametrised self-checking scoreboard for UART Tx-to-Rx loopback benches; successor to the single-byte Tx/Rx checker.
- Queues every byte handed to the transmitter in an in-order expected-data FIFO and compares each received byte against the FIFO head.
- Keeps match/error counters, captures the first mismatch, and flags overflow, underflow and receive timeout.
- Sits in the testbench beside the UART Tx/Rx pair. Synthesisable so it can also be used as an on-chip BIST monitor.

---
 rtl/uart_loopback_scoreboard.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_uart_loopback_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_scoreboard.sv
// uart_loopback_scoreboard
// In-order expected-data scoreboard for UART Tx->Rx loopback.
// Every byte the transmitter accepts is queued. Each received byte is compared
// against the oldest queued byte. The block keeps saturating match/error
// counters, captures the first mismatch, and raises sticky overflow,
// underflow and timeout flags.
// Optional macro SCB_ASSERT_EN compiles a concurrent-assertion checker
// alongside the datapath. The counters and flags behave the same without it.
// If a timeout coincides with a push, the flush discards that push as well.
// The timeout flag already reports the lost stream.

`ifdef SCB_ASSERT_EN
module uart_loopback_scoreboard_chk #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_Tx_DV,
  input  logic              i_Rx_DV,
  input  logic [DATA_W-1:0] i_Rx_Byte,
  input  logic [DATA_W-1:0] head_byte,
  input  logic              empty,
  input  logic              full,
  input  logic [CNT_W-1:0]  err_cnt
);

  // A compare against a non-empty FIFO must not raise the error count.
  a_rx_match: assert property (@(posedge clk) disable iff (rst)
    (i_Rx_DV && !empty && !i_clear) |=> (err_cnt == $past(err_cnt)))
    else $error("FAIL | Expected=%0h | Got=%0h", $past(head_byte), $past(i_Rx_Byte));

  // The transmitter side should never push into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_Tx_DV && full))
    else $error("push while expected FIFO full");

  // The receiver side should never deliver a byte with nothing expected.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(i_Rx_DV && empty))
    else $error("receive while expected FIFO empty");

  // Both strobes are single-cycle pulses.
  a_tx_pulse: assert property (@(posedge clk) disable iff (rst)
    i_Tx_DV |=> !i_Tx_DV)
    else $error("i_Tx_DV held longer than one cycle");

  a_rx_pulse: assert property (@(posedge clk) disable iff (rst)
    i_Rx_DV |=> !i_Rx_DV)
    else $error("i_Rx_DV held longer than one cycle");

endmodule
`endif

module uart_loopback_scoreboard #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_Tx_DV,
  input  logic [DATA_W-1:0]          i_Tx_Byte,
  input  logic                       i_Rx_DV,
  input  logic [DATA_W-1:0]          i_Rx_Byte,
  input  logic                       i_clear,
  output logic [$clog2(DEPTH):0]     o_pending,
  output logic [CNT_W-1:0]           o_match_cnt,
  output logic [CNT_W-1:0]           o_err_cnt,
  output logic                       o_err,
  output logic [DATA_W-1:0]          o_first_exp,
  output logic [DATA_W-1:0]          o_first_got,
  output logic                       o_overflow,
  output logic                       o_underflow,
  output logic                       o_timeout,
  output logic                       o_busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PEND_W = PTR_W + 1;
  localparam int AGE_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [PEND_W-1:0] FULL_LVL = PEND_W'(DEPTH);
  localparam logic [AGE_W-1:0]  AGE_LAST = AGE_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic              TOUT_EN  = (TIMEOUT_CYC > 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [PEND_W-1:0] pending_r;
  logic [1:0]        state_r;
  logic [AGE_W-1:0]  age_r;
  logic [CNT_W-1:0]  match_cnt_r, err_cnt_r;
  logic              err_r, overflow_r, underflow_r, timeout_r, busy_r;
  logic              first_seen_r;
  logic [DATA_W-1:0] first_exp_r, first_got_r;

  logic              empty_s, full_s;
  logic [DATA_W-1:0] head_s;
  logic              pop_s, push_s, match_s, mismatch_s;
  logic              underflow_ev_s, overflow_ev_s, timeout_ev_s;
  logic [PEND_W-1:0] pending_nx_s;
  logic [PTR_W-1:0]  wr_ptr_nx_s, rd_ptr_nx_s;
  logic [1:0]        state_nx_s;
  logic [AGE_W-1:0]  age_nx_s;

  // Decode this cycle's events from the strobes and the FIFO level.
  always_comb begin
    empty_s        = (pending_r == PEND_W'(0));
    full_s         = (pending_r == FULL_LVL);
    head_s         = mem_r[rd_ptr_r];
    pop_s          = i_Rx_DV && !empty_s;
    underflow_ev_s = i_Rx_DV && empty_s;
    match_s        = pop_s && (i_Rx_Byte == head_s);
    mismatch_s     = pop_s && (i_Rx_Byte != head_s);
    timeout_ev_s   = TOUT_EN && (state_r == ST_WAIT) && !pop_s && (age_r == AGE_LAST);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    push_s         = i_Tx_DV && (!full_s || pop_s) && !timeout_ev_s;
    overflow_ev_s  = i_Tx_DV && full_s && !pop_s && !timeout_ev_s;
  end

  // Next FIFO level and pointers. A timeout flushes by snapping the read pointer to the write pointer.
  always_comb begin
    pending_nx_s = pending_r;
    rd_ptr_nx_s  = rd_ptr_r;
    wr_ptr_nx_s  = wr_ptr_r;
    if (timeout_ev_s) begin
      pending_nx_s = PEND_W'(0);
      rd_ptr_nx_s  = wr_ptr_r;
    end else begin
      case ({push_s, pop_s})
        2'b10:   pending_nx_s = pending_r + PEND_W'(1);
        2'b01:   pending_nx_s = pending_r - PEND_W'(1);
        default: pending_nx_s = pending_r;
      endcase
      if (pop_s) begin
        rd_ptr_nx_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nx_s = rd_ptr_r;
      end
    end
    if (push_s) begin
      wr_ptr_nx_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_nx_s = wr_ptr_r;
    end
  end

  // Next FSM state and head-entry age.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (push_s) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (timeout_ev_s) begin
          state_nx_s = ST_TOUT;
        end else if (pending_nx_s == PEND_W'(0)) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_TOUT: begin
        if (push_s) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
    // The age restarts whenever a new entry becomes the head, so it measures the current head's wait.
    if (TOUT_EN && (state_r == ST_WAIT) && (state_nx_s == ST_WAIT) && !pop_s) begin
      age_nx_s = age_r + AGE_W'(1);
    end else begin
      age_nx_s = AGE_W'(0);
    end
  end

  // Expected-byte storage. The data needs no reset because occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_s && !i_clear) begin
      mem_r[wr_ptr_r] <= i_Tx_Byte;
    end
  end

  // Control, counters and sticky flags. A clear outranks everything else in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= PTR_W'(0);
      rd_ptr_r     <= PTR_W'(0);
      pending_r    <= PEND_W'(0);
      state_r      <= ST_IDLE;
      age_r        <= AGE_W'(0);
      match_cnt_r  <= CNT_W'(0);
      err_cnt_r    <= CNT_W'(0);
      err_r        <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
      timeout_r    <= 1'b0;
      busy_r       <= 1'b0;
      first_seen_r <= 1'b0;
      first_exp_r  <= DATA_W'(0);
      first_got_r  <= DATA_W'(0);
    end else if (i_clear) begin
      wr_ptr_r     <= PTR_W'(0);
      rd_ptr_r     <= PTR_W'(0);
      pending_r    <= PEND_W'(0);
      state_r      <= ST_IDLE;
      age_r        <= AGE_W'(0);
      match_cnt_r  <= CNT_W'(0);
      err_cnt_r    <= CNT_W'(0);
      err_r        <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
      timeout_r    <= 1'b0;
      busy_r       <= 1'b0;
      first_seen_r <= 1'b0;
      first_exp_r  <= DATA_W'(0);
      first_got_r  <= DATA_W'(0);
    end else begin
      wr_ptr_r    <= wr_ptr_nx_s;
      rd_ptr_r    <= rd_ptr_nx_s;
      pending_r   <= pending_nx_s;
      state_r     <= state_nx_s;
      age_r       <= age_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
      err_r       <= err_r | mismatch_s | underflow_ev_s | overflow_ev_s | timeout_ev_s;
      overflow_r  <= overflow_r | overflow_ev_s;
      underflow_r <= underflow_r | underflow_ev_s;
      timeout_r   <= timeout_r | timeout_ev_s;
      if (match_s) begin
        match_cnt_r <= sat_inc(match_cnt_r);
      end
      if (mismatch_s) begin
        err_cnt_r <= sat_inc(err_cnt_r);
      end
      // Only the first mismatch is kept, which is the one that explains a failing run.
      if (mismatch_s && !first_seen_r) begin
        first_seen_r <= 1'b1;
        first_exp_r  <= head_s;
        first_got_r  <= i_Rx_Byte;
      end
    end
  end

  assign o_pending   = pending_r;
  assign o_match_cnt = match_cnt_r;
  assign o_err_cnt   = err_cnt_r;
  assign o_err       = err_r;
  assign o_first_exp = first_exp_r;
  assign o_first_got = first_got_r;
  assign o_overflow  = overflow_r;
  assign o_underflow = underflow_r;
  assign o_timeout   = timeout_r;
  assign o_busy      = busy_r;

`ifdef SCB_ASSERT_EN
  uart_loopback_scoreboard_chk #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (i_clear),
    .i_Tx_DV   (i_Tx_DV),
    .i_Rx_DV   (i_Rx_DV),
    .i_Rx_Byte (i_Rx_Byte),
    .head_byte (head_s),
    .empty     (empty_s),
    .full      (full_s),
    .err_cnt   (err_cnt_r)
  );
`else
  // The checker is not built. The datapath above is unchanged.
`endif

endmodule

// File: tb/tb_uart_loopback_scoreboard.sv
// Testbench for uart_loopback_scoreboard. A queue-based reference model of the
// expected stream is checked against the DUT on every falling edge. Directed
// scenarios pin literal values, and randomized traffic follows them.
module tb_uart_loopback_scoreboard;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;
  localparam int TOUT   = 50;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_dv, rx_dv, clr;
  logic [DATA_W-1:0] tx_byte, rx_byte;
  logic [$clog2(DEPTH):0] o_pending;
  logic [CNT_W-1:0]  o_match_cnt, o_err_cnt;
  logic              o_err, o_overflow, o_underflow, o_timeout, o_busy;
  logic [DATA_W-1:0] o_first_exp, o_first_got;

  always #5 clk = ~clk;

  uart_loopback_scoreboard #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_clear(clr),
    .o_pending(o_pending), .o_match_cnt(o_match_cnt), .o_err_cnt(o_err_cnt),
    .o_err(o_err), .o_first_exp(o_first_exp), .o_first_got(o_first_got),
    .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic [DATA_W-1:0] m_q[$];
  int  m_match, m_errc, m_age;
  bit  m_err, m_ovf, m_unf, m_tout, m_busy, m_first_seen;
  logic [DATA_W-1:0] m_fexp, m_fgot;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_match = 0; m_errc = 0; m_age = 0;
    m_err = 0; m_ovf = 0; m_unf = 0; m_tout = 0; m_busy = 0; m_first_seen = 0;
    m_fexp = '0; m_fgot = '0;
  endtask

  // One clock edge of the specification's behaviour, using the inputs present at that edge.
  task automatic model_step();
    logic [DATA_W-1:0] e;
    bit had, popped, timed_out;
    if (rst || clr) begin
      model_reset();
      return;
    end
    had = (m_q.size() > 0);
    popped = 0;
    timed_out = had && !rx_dv && (TOUT > 0) && (m_age + 1 == TOUT);
    if (timed_out) begin
      m_q.delete();
      m_tout = 1; m_err = 1; m_age = 0;
    end else begin
      if (rx_dv) begin
        if (had) begin
          e = m_q.pop_front();
          popped = 1;
          if (e == rx_byte) begin
            if (m_match < CMAX) m_match++;
          end else begin
            if (m_errc < CMAX) m_errc++;
            m_err = 1;
            if (!m_first_seen) begin
              m_first_seen = 1; m_fexp = e; m_fgot = rx_byte;
            end
          end
        end else begin
          m_unf = 1; m_err = 1;
        end
      end
      if (tx_dv) begin
        if (m_q.size() < DEPTH) m_q.push_back(tx_byte);
        else begin m_ovf = 1; m_err = 1; end
      end
      if (popped || !had) m_age = 0;
      else m_age++;
    end
    m_busy = (m_q.size() > 0) || timed_out;
  endtask

  // Compare every DUT output with the model once per cycle.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("pending",   32'(o_pending),   32'(m_q.size()));
      chk("match_cnt", 32'(o_match_cnt), 32'(m_match));
      chk("err_cnt",   32'(o_err_cnt),   32'(m_errc));
      chk("err",       32'(o_err),       32'(m_err));
      chk("first_exp", 32'(o_first_exp), 32'(m_fexp));
      chk("first_got", 32'(o_first_got), 32'(m_fgot));
      chk("overflow",  32'(o_overflow),  32'(m_ovf));
      chk("underflow", 32'(o_underflow), 32'(m_unf));
      chk("timeout",   32'(o_timeout),   32'(m_tout));
      chk("busy",      32'(o_busy),      32'(m_busy));
    end
  end

  // Drive one cycle of inputs, advance the model at the edge, and return 2 time units after the edge.
  task automatic step(input logic t, input logic [7:0] tb, input logic r, input logic [7:0] rb, input logic c);
    tx_dv = t; tx_byte = tb; rx_dv = r; rx_byte = rb; clr = c;
    @(posedge clk);
    model_step();
    #2;
    tx_dv = 1'b0; rx_dv = 1'b0; clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] b); step(1'b1, b, 1'b0, 8'h00, 1'b0); endtask
  task automatic recv(input logic [7:0] b); step(1'b0, 8'h00, 1'b1, b, 1'b0); endtask
  task automatic idle();                    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); endtask
  task automatic clear();                   step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=time limit expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] bytes4 [4];
    logic t, r, c;
    logic [7:0] tb, rb;
    bit quiet;
    bytes4[0] = 8'h55; bytes4[1] = 8'hA3; bytes4[2] = 8'h00; bytes4[3] = 8'hFF;
    rst = 1'b1; tx_dv = 1'b0; rx_dv = 1'b0; clr = 1'b0; tx_byte = 8'h00; rx_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_pending", 32'(o_pending), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_err", 32'(o_err), 32'd0);

    // In-order matches.
    for (int i = 0; i < 4; i++) push(bytes4[i]);
    chk("s1_pending4", 32'(o_pending), 32'd4);
    chk("s1_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 4; i++) recv(bytes4[i]);
    chk("s1_match", 32'(o_match_cnt), 32'd4);
    chk("s1_errcnt", 32'(o_err_cnt), 32'd0);
    chk("s1_err", 32'(o_err), 32'd0);
    chk("s1_pending0", 32'(o_pending), 32'd0);
    chk("s1_idle", 32'(o_busy), 32'd0);

    // First-mismatch capture.
    clear();
    push(8'h12); push(8'h34); recv(8'h12); recv(8'h35);
    chk("s2_match", 32'(o_match_cnt), 32'd1);
    chk("s2_errcnt", 32'(o_err_cnt), 32'd1);
    chk("s2_fexp", 32'(o_first_exp), 32'h34);
    chk("s2_fgot", 32'(o_first_got), 32'h35);
    chk("s2_err", 32'(o_err), 32'd1);
    push(8'h56); recv(8'h57);
    chk("s2_errcnt2", 32'(o_err_cnt), 32'd2);
    chk("s2_fexp_kept", 32'(o_first_exp), 32'h34);
    chk("s2_fgot_kept", 32'(o_first_got), 32'h35);

    // Overflow, then underflow.
    clear();
    for (int i = 0; i < 17; i++) push(8'(i + 8'h40));
    chk("s3_overflow", 32'(o_overflow), 32'd1);
    chk("s3_pending16", 32'(o_pending), 32'd16);
    clear();
    recv(8'h99);
    chk("s3_underflow", 32'(o_underflow), 32'd1);
    chk("s3_match0", 32'(o_match_cnt), 32'd0);
    chk("s3_err0", 32'(o_err_cnt), 32'd0);

    // Full FIFO with simultaneous push and matching pop.
    clear();
    for (int i = 0; i < 16; i++) push(8'(i));
    step(1'b1, 8'hAB, 1'b1, 8'h00, 1'b0);
    chk("s5_no_ovf", 32'(o_overflow), 32'd0);
    chk("s5_pending16", 32'(o_pending), 32'd16);
    chk("s5_match1", 32'(o_match_cnt), 32'd1);

    // Timeout 50 cycles after a lone push.
    clear();
    push(8'h3C);
    chk("s4_pending1", 32'(o_pending), 32'd1);
    for (int i = 1; i <= TOUT; i++) begin
      idle();
      if (i == TOUT - 1) chk("s4_not_yet", 32'(o_timeout), 32'd0);
    end
    chk("s4_timeout", 32'(o_timeout), 32'd1);
    chk("s4_pending0", 32'(o_pending), 32'd0);
    chk("s4_busy_tout", 32'(o_busy), 32'd1);
    idle();
    chk("s4_busy_idle", 32'(o_busy), 32'd0);

    // Asynchronous reset mid-stream.
    clear();
    recv(8'h11);
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    chk("s6_pending5", 32'(o_pending), 32'd5);
    rst = 1'b1;
    #1;
    chk("s6_rst_pending", 32'(o_pending), 32'd0);
    chk("s6_rst_err", 32'(o_err), 32'd0);
    chk("s6_rst_unf", 32'(o_underflow), 32'd0);
    chk("s6_rst_busy", 32'(o_busy), 32'd0);
    model_reset();
    idle();
    rst = 1'b0;
    push(8'h21);
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    chk("s6_clear_push", 32'(o_pending), 32'd0);

    // Counter saturation.
    for (int i = 0; i < 260; i++) begin push(8'(i)); recv(8'(i)); end
    chk("sat_match", 32'(o_match_cnt), 32'(CMAX));
    for (int i = 0; i < 260; i++) begin push(8'(i)); recv(8'(~i)); end
    chk("sat_err", 32'(o_err_cnt), 32'(CMAX));

    // Randomized traffic with periodic receive gaps long enough to time out.
    clear();
    for (int n = 0; n < 3000; n++) begin
      quiet = ((n % 500) >= 400) && ((n % 500) < 470);
      t  = ($urandom % 100) < 40;
      r  = !quiet && (($urandom % 100) < 40);
      tb = 8'($urandom);
      rb = (m_q.size() > 0 && ($urandom % 10) != 0) ? m_q[0] : 8'($urandom);
      c  = ($urandom % 1000) == 0;
      step(t, tb, r, rb, c);
    end
    idle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
